// File: rtl/seven_seg_scan_ctrl_if.sv
// Bus between the datapath and the seven-segment scan controller.
// Optional decimal-point lines exist only when SEG_SCAN_DP_EN is defined.
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [4*NUM_DIGITS-1:0] values;
  logic                    load;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   anode;
  logic [6:0]              segs;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_done;
`ifdef SEG_SCAN_DP_EN
  logic [NUM_DIGITS-1:0]   dp;
  logic                    dp_n;

  modport master (
    output values, load, digit_en, dp,
    input  anode, segs, digit_idx, frame_done, dp_n
  );
  modport slave (
    input  values, load, digit_en, dp,
    output anode, segs, digit_idx, frame_done, dp_n
  );
`else
  modport master (
    output values, load, digit_en,
    input  anode, segs, digit_idx, frame_done
  );
  modport slave (
    input  values, load, digit_en,
    output anode, segs, digit_idx, frame_done
  );
`endif
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed hex display scanner with frame-synchronous double buffering.
// Define SEG_SCAN_DP_EN to add per-digit decimal points (dp in, dp_n out).
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic                  clk,
  input logic                  rst_n,
  seven_seg_scan_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [4*NUM_DIGITS-1:0] pend_reg, pend_next;
  logic [4*NUM_DIGITS-1:0] disp_reg, disp_next;
  logic [NUM_DIGITS-1:0]   anode_reg, anode_next;
  logic [6:0]              segs_reg, segs_next;
  logic                    frame_done_reg;
  logic                    slot_end, boundary, show;
  logic [3:0]              cur_nibble;

  function automatic logic [6:0] hex_to_segs(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  assign slot_end   = (cnt_reg == CNT_LAST);
  assign boundary   = slot_end && (idx_reg == IDX_LAST);
  assign cur_nibble = disp_reg[{idx_reg, 2'b00} +: 4];
  // digit_en is deliberately used live so a digit can be blanked mid-frame.
  assign show       = (cnt_reg >= CNT_BLANK) && bus.digit_en[idx_reg];

  always_comb begin
    cnt_next  = slot_end ? '0 : cnt_reg + 1'b1;
    idx_next  = idx_reg;
    if (slot_end) begin
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end
    // A load on the boundary cycle lands in both buffers via pend_next.
    pend_next = bus.load ? bus.values : pend_reg;
    disp_next = boundary ? pend_next : disp_reg;
    segs_next = show ? hex_to_segs(cur_nibble) : 7'h7F;
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
    assign anode_next[gi] = ~(show && (idx_reg == IDX_W'(gi)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      pend_reg       <= '0;
      disp_reg       <= '0;
      anode_reg      <= '1;
      segs_reg       <= 7'h7F;
      frame_done_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      pend_reg       <= pend_next;
      disp_reg       <= disp_next;
      anode_reg      <= anode_next;
      segs_reg       <= segs_next;
      frame_done_reg <= boundary;
    end
  end

  assign bus.anode      = anode_reg;
  assign bus.segs       = segs_reg;
  assign bus.digit_idx  = idx_reg;
  assign bus.frame_done = frame_done_reg;

`ifdef SEG_SCAN_DP_EN
  logic [NUM_DIGITS-1:0] pend_dp_reg, disp_dp_reg;
  logic                  dp_n_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_dp_reg <= '0;
      disp_dp_reg <= '0;
      dp_n_reg    <= 1'b1;
    end else begin
      if (bus.load) pend_dp_reg <= bus.dp;
      if (boundary) disp_dp_reg <= bus.load ? bus.dp : pend_dp_reg;
      dp_n_reg <= ~(show && disp_dp_reg[idx_reg]);
    end
  end

  assign bus.dp_n = dp_n_reg;
`endif
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl (4 digits, 4-cycle slots, 1 blank cycle).
// Honours SEG_SCAN_DP_EN when defined at compile time.
module tb_seven_seg_scan_ctrl;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BC = 1;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] segs;
    logic [1:0] idx;
    logic       fd;
    logic       dpn;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  // Reference decode table, active-low GFEDCBA.
  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model state
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_disp = '0;
  logic [3:0]  m_pdp = '0;
  logic [3:0]  m_ddp = '0;

  seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %0h, wanted %0h at %0t", tag, got, want, $time);
  endtask

  // Predict the outputs after the coming edge, advance the model, then clock.
  task automatic step();
    exp_t       e;
    logic       blank, bnd;
    logic [3:0] dp_in;
`ifdef SEG_SCAN_DP_EN
    dp_in = bus.dp;
`else
    dp_in = '0;
`endif
    e = '0;
    if (!rst_n) begin
      e.anode = 4'hF; e.segs = 7'h7F; e.idx = 2'd0; e.fd = 1'b0; e.dpn = 1'b1;
      m_cnt = 0; m_idx = 0; m_pend = '0; m_disp = '0; m_pdp = '0; m_ddp = '0;
    end else begin
      bnd   = (m_cnt == RD - 1) && (m_idx == ND - 1);
      blank = (m_cnt < BC) || !bus.digit_en[m_idx];
      e.anode = blank ? 4'hF : ~(4'b0001 << m_idx);
      e.segs  = blank ? 7'h7F : seg_tab[m_disp[m_idx*4 +: 4]];
      e.dpn   = blank ? 1'b1 : ~m_ddp[m_idx];
      e.fd    = bnd;
      if (bus.load) begin m_pend = bus.values; m_pdp = dp_in; end
      if (bnd) begin m_disp = m_pend; m_ddp = m_pdp; end
      if (m_cnt == RD - 1) begin
        m_cnt = 0;
        m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
      end else begin
        m_cnt++;
      end
      e.idx = 2'(m_idx);
    end
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_word(input logic [15:0] v);
    bus.values = v;
    bus.load   = 1'b1;
    $display("load values=%04h at cnt=%0d idx=%0d t=%0t", v, m_cnt, m_idx, $time);
    step();
    bus.load   = 1'b0;
  endtask

  task automatic wait_slot(input int idx, input int cnt);
    for (int i = 0; i < 40 && !(m_idx == idx && m_cnt == cnt); i++) step();
    check("sync", {31'd0, (m_idx == idx && m_cnt == cnt)}, 32'd1);
  endtask

  // Monitor: pop one prediction per edge and compare.
  int last_fd = -1;
  int cyc     = 0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("anode", {28'd0, bus.anode}, {28'd0, e.anode});
      check("segs", {25'd0, bus.segs}, {25'd0, e.segs});
      check("digit_idx", {30'd0, bus.digit_idx}, {30'd0, e.idx});
      check("frame_done", {31'd0, bus.frame_done}, {31'd0, e.fd});
      check("onehot", {31'd0, ($countones(~bus.anode) <= 1)}, 32'd1);
`ifdef SEG_SCAN_DP_EN
      check("dp_n", {31'd0, bus.dp_n}, {31'd0, e.dpn});
`endif
    end
    if (!rst_n) begin
      last_fd = -1;
    end else if (bus.frame_done) begin
      if (last_fd >= 0) check("fd_period", cyc - last_fd, ND * RD);
      last_fd = cyc;
    end
  end

  initial begin
    rst_n        = 1'b0;
    bus.values   = '0;
    bus.load     = 1'b0;
    bus.digit_en = 4'hF;
`ifdef SEG_SCAN_DP_EN
    bus.dp       = '0;
`endif
    run(3);
    rst_n = 1'b1;

    // Scenario 1/2: first frame shows zeros, then F5A0; three more frames.
    load_word(16'hF5A0);
    run(64);

    // Scenario 3: two loads in one frame, last one wins next frame.
    wait_slot(1, 1);
    load_word(16'h1111);
    run(2);
    load_word(16'h2222);
    run(40);

    // Scenario 4: load exactly on the boundary cycle.
    wait_slot(ND - 1, RD - 1);
    load_word(16'h3333);
    run(40);

    // Scenario 5: partial digit enables.
    bus.digit_en = 4'b0101;
    run(20);
    bus.digit_en = 4'hF;

    // Scenario 6: reset mid-slot on digit 2, then run with a decimal point on digit 0.
    wait_slot(2, 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
`ifdef SEG_SCAN_DP_EN
    bus.dp = 4'b0001;
    load_word(16'h0000);
    bus.dp = 4'b0000;
`endif
    run(40);

    check("drain", q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed hex display controller for an N-digit common-anode seven-segment display.
- Holds a tear-free double-buffered copy of N 4-bit nibbles.
- Scans one digit per refresh slot, decodes its nibble to GFEDCBA segments and drives the active-low anode strobe.
- Sits between the arithmetic/datapath (A, B, A+B, A-B nibbles) and the board display pins, replacing the hand-supplied anode pattern with an internal scanner.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; 2..8.
- REFRESH_DIV, 100000: clock cycles per digit slot; >= 2.
- BLANK_CYCLES, 1000: anti-ghosting blank cycles at the start of each slot; 0 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: synchronous active-low reset.
- values, input, 4*NUM_DIGITS: nibble k in bits [4k+3:4k]; digit 0 is the rightmost.
- load, input, 1: capture values into the pending buffer this cycle.
- digit_en, input, NUM_DIGITS: 1 = digit shown, 0 = digit blanked (anode held high).
- anode, output, NUM_DIGITS: active-low one-hot digit strobe.
- segs, output, 7: active-low GFEDCBA pattern.
- digit_idx, output, clog2(NUM_DIGITS): index of the current slot.
- frame_done, output, 1: one-cycle pulse when the last slot ends.

Behaviour:
- Reset (rst_n low at a clk edge) sets:
  - slot counter cnt = 0, digit_idx = 0;
  - pending and display buffers = 0;
  - anode = all 1s, segs = 7'b1111111, frame_done = 0.
- Reset mid-frame aborts the scan immediately. The first visible digit after reset release is digit 0, at cycle BLANK_CYCLES+1.
- Slot counter:
  - cnt counts 0..REFRESH_DIV-1.
  - At cnt == REFRESH_DIV-1, cnt goes to 0 and digit_idx increments.
  - digit_idx wraps from NUM_DIGITS-1 to 0.
- Frame boundary is the cycle where cnt == REFRESH_DIV-1 and digit_idx == NUM_DIGITS-1.
  - frame_done is registered and high for exactly the cycle after the boundary.
- Buffering:
  - load=1 copies values into the pending buffer.
  - At a frame boundary, pending is copied to the display buffer.
  - load=1 on the boundary cycle copies values directly into both buffers. The new data is shown from the next frame.
  - Multiple loads within one frame: the last one wins.
  - Display contents never change mid-frame.
- Outputs are registered with 1-cycle latency from the (cnt, digit_idx) state:
  - If cnt < BLANK_CYCLES, or digit_en[digit_idx] == 0: anode = all 1s, segs = 7'b1111111.
  - Otherwise: anode = ~(1 << digit_idx), and segs = decode(display[digit_idx]).
- Decode table (GFEDCBA, active-low):

  | Nibble | segs      | Nibble | segs      |
  |--------|-----------|--------|-----------|
  | 0      | 1000000   | 8      | 0000000   |
  | 1      | 1111001   | 9      | 0010000   |
  | 2      | 0100100   | A      | 0001000   |
  | 3      | 0110000   | b      | 0000011   |
  | 4      | 0011001   | C      | 1000110   |
  | 5      | 0010010   | d      | 0100001   |
  | 6      | 0000010   | E      | 0000110   |
  | 7      | 1111000   | F      | 0001110   |

  - The decode is fully specified for every input; no latches.
- At most one anode bit is ever low.
- digit_en is sampled live, not buffered.

Optional Feature:
Macro SEG_SCAN_DP_EN.
- Defined:
  - Adds input dp (NUM_DIGITS bits; 1 = point on) and output dp_n (1 bit, active-low).
  - dp is buffered alongside values through the pending and display buffers.
  - dp_n follows the same blank/latency rules as segs.
  - dp_n resets to 1.
- Not defined: neither port exists. Behaviour is otherwise identical.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
1. Reset, then load values=16'hF5A0 with digit_en=4'hF.
   - During the first frame, display = 0: segs=1000000 on all digits.
   - After frame_done, per slot: 1000000/anode 1110, 0001000/1101, 0010010/1011, 0001110/0111.
   - In every slot, the first cycle is blanked (anode 1111).
2. Run 3 frames.
   - frame_done pulses every 16 cycles, one cycle wide.
   - digit_idx sequence is 0,1,2,3,0.
   - anode is never more than one-hot-low.
3. Load 16'h1111 mid-frame, then 16'h2222 in the same frame.
   - The current frame is unchanged.
   - The next frame shows 2 (0100100) on every digit.
4. Assert load=1 with 16'h3333 exactly on a boundary cycle.
   - The next frame shows 0110000 on every digit.
5. Set digit_en=4'b0101.
   - Digits 1 and 3 have anode 1111 and segs 1111111 during their slots.
   - Digits 0 and 2 are unaffected.
6. Pull rst_n low mid-slot on digit 2.
   - The next cycle gives anode 1111, segs 1111111, digit_idx 0.
   - Display data cleared to 0.
   - With SEG_SCAN_DP_EN defined, dp=4'b0001 gives dp_n=0 only in digit 0's unblanked cycles.
